// File: rtl/window_trap_sequencer.sv
// Sequences SAVE/RESTORE/illegal-instruction micro-operations onto the ALU and special-register write port.
// Every output is a flop loaded from a decode of the next state, so outputs line up with the state they describe.
module window_trap_sequencer #(
  parameter int          NWIN       = 4,
  parameter logic [5:0]  RESTORE_OP = 6'b111010
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req_Valid,
  input  logic [1:0]  Req_Kind,
  input  logic [31:0] PSR_In,
  input  logic [31:0] WIM_In,
  output logic        Req_Ready,
  output logic [5:0]  ALU_Opcode,
  output logic [1:0]  Dest_Sel,
  output logic        Wr_En,
  output logic        Done,
  output logic        Trap_Taken,
  output logic [7:0]  Trap_Type,
  output logic        Error_Mode,
  output logic [2:0]  Dbg_State
);

  // Handshake: a request transfers on a rising Clk edge where Req_Valid and
  // Req_Ready are both high; Req_Ready is high only while idle, and the
  // request fields are captured on that edge and ignored until the next transfer.

  localparam int CW = (NWIN > 1) ? $clog2(NWIN) : 1;

  localparam logic [1:0] KIND_SAVE    = 2'b00;
  localparam logic [1:0] KIND_RESTORE = 2'b01;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_PSR  = 2'b01;
  localparam logic [1:0] DEST_TBR  = 2'b10;

  localparam logic [5:0] OP_NONE      = 6'b000000;
  localparam logic [5:0] OP_SAVE      = 6'b111110;
  localparam logic [5:0] OP_OVF_TBR   = 6'b111000;
  localparam logic [5:0] OP_UNF_TBR   = 6'b101001;
  localparam logic [5:0] OP_ILL_TBR   = 6'b111011;
  localparam logic [5:0] OP_OVF_PSR   = 6'b110000;
  localparam logic [5:0] OP_UNF_PSR   = 6'b111101;
  localparam logic [5:0] OP_ILL_PSR   = 6'b101111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_COMMIT = 3'd2,
    S_WR_TBR = 3'd3,
    S_WR_PSR = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_OVF  = 2'd1,
    T_UNF  = 2'd2,
    T_ILL  = 2'd3
  } trap_e;

  state_e            state_q, state_d;
  trap_e             trap_q, trap_d;
  logic [1:0]        kind_q, kind_d;
  logic [4:0]        cwp_q, cwp_d;
  logic [NWIN-1:0]   wim_q, wim_d;
  logic              et_q, et_d;

  logic              ready_q, ready_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [1:0]        dest_q, dest_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              taken_q, taken_d;
  logic [7:0]        ttype_q, ttype_d;
  logic              error_q, error_d;

  logic [4:0]        ncwp_save, ncwp_rest;
  trap_e             trap_check;

  // cwp_q is already reduced modulo NWIN, so only the wrap points need care.
  assign ncwp_save = (cwp_q == 5'd0) ? 5'(NWIN - 1) : cwp_q - 5'd1;
  assign ncwp_rest = (cwp_q == 5'(NWIN - 1)) ? 5'd0 : cwp_q + 5'd1;

  always_comb begin
    trap_check = T_NONE;
    case (kind_q)
      KIND_SAVE:    trap_check = wim_q[ncwp_save[CW-1:0]] ? T_OVF : T_NONE;
      KIND_RESTORE: trap_check = wim_q[ncwp_rest[CW-1:0]] ? T_UNF : T_NONE;
      default:      trap_check = T_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    kind_d  = kind_q;
    cwp_d   = cwp_q;
    wim_d   = wim_q;
    et_d    = et_q;
    case (state_q)
      S_IDLE: begin
        if (Req_Valid && ready_q) begin
          kind_d  = Req_Kind;
          cwp_d   = 5'({1'b0, PSR_In[4:0]} % 6'(NWIN));
          wim_d   = WIM_In[NWIN-1:0];
          et_d    = PSR_In[5];
          trap_d  = T_NONE;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        trap_d = trap_check;
        if (trap_check == T_NONE) state_d = S_COMMIT;
        else if (et_q)            state_d = S_WR_TBR;
        else                      state_d = S_ERROR;
      end
      S_COMMIT: state_d = S_DONE;
      S_WR_TBR: state_d = S_WR_PSR;
      S_WR_PSR: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    opcode_d = OP_NONE;
    dest_d   = DEST_NONE;
    wr_en_d  = 1'b0;
    done_d   = 1'b0;
    taken_d  = 1'b0;
    ttype_d  = 8'h00;
    error_d  = error_q | (state_d == S_ERROR);
    case (state_d)
      S_COMMIT: begin
        wr_en_d  = 1'b1;
        dest_d   = DEST_PSR;
        opcode_d = (kind_q == KIND_SAVE) ? OP_SAVE : RESTORE_OP;
      end
      S_WR_TBR: begin
        wr_en_d = 1'b1;
        dest_d  = DEST_TBR;
        case (trap_d)
          T_OVF:   opcode_d = OP_OVF_TBR;
          T_UNF:   opcode_d = OP_UNF_TBR;
          default: opcode_d = OP_ILL_TBR;
        endcase
      end
      S_WR_PSR: begin
        wr_en_d = 1'b1;
        dest_d  = DEST_PSR;
        case (trap_d)
          T_OVF:   opcode_d = OP_OVF_PSR;
          T_UNF:   opcode_d = OP_UNF_PSR;
          default: opcode_d = OP_ILL_PSR;
        endcase
      end
      S_DONE: begin
        done_d  = 1'b1;
        taken_d = (trap_d != T_NONE);
        case (trap_d)
          T_OVF:   ttype_d = 8'h05;
          T_UNF:   ttype_d = 8'h06;
          T_ILL:   ttype_d = 8'h02;
          default: ttype_d = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      trap_q   <= T_NONE;
      kind_q   <= 2'b00;
      cwp_q    <= 5'd0;
      wim_q    <= '0;
      et_q     <= 1'b0;
      ready_q  <= 1'b1;
      opcode_q <= OP_NONE;
      dest_q   <= DEST_NONE;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      ttype_q  <= 8'h00;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      trap_q   <= trap_d;
      kind_q   <= kind_d;
      cwp_q    <= cwp_d;
      wim_q    <= wim_d;
      et_q     <= et_d;
      ready_q  <= ready_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
      ttype_q  <= ttype_d;
      error_q  <= error_d;
    end
  end

  assign Req_Ready  = ready_q;
  assign ALU_Opcode = opcode_q;
  assign Dest_Sel   = dest_q;
  assign Wr_En      = wr_en_q;
  assign Done       = done_q;
  assign Trap_Taken = taken_q;
  assign Trap_Type  = ttype_q;
  assign Error_Mode = error_q;
  assign Dbg_State  = state_q;

endmodule
